// File: rtl/cgra_fu_pkg.sv
// Shared definitions for the CGRA functional-unit stage: opcode encodings.
package cgra_fu_pkg;

  localparam int FU_OP_WIDTH = 4;

  typedef enum logic [FU_OP_WIDTH-1:0] {
    FU_ADD    = 4'd0,
    FU_SUB    = 4'd1,
    FU_MUL    = 4'd2,
    FU_AND    = 4'd3,
    FU_OR     = 4'd4,
    FU_XOR    = 4'd5,
    FU_SLL    = 4'd6,
    FU_SRL    = 4'd7,
    FU_SRA    = 4'd8,
    FU_SLT    = 4'd9,
    FU_SLTU   = 4'd10,
    FU_PASS_A = 4'd11
  } fu_op_e;

endpackage

// File: rtl/cgra_alu.sv
// Combinational ALU for the CGRA functional unit. Undefined opcodes yield 0.
module cgra_alu
  import cgra_fu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [FU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  output logic [DATA_WIDTH-1:0]  res
);

  localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [SHW-1:0] w_sh;
  logic           w_slt;
  logic           w_sltu;

  // Shift amount uses only the low bits of b so any b is a legal shift.
  assign w_sh   = b[SHW-1:0];
  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  // Operation select; every result is truncated to DATA_WIDTH.
  always_comb begin
    res = '0;
    case (fu_op_e'(op))
      FU_ADD:    res = a + b;
      FU_SUB:    res = a - b;
      FU_MUL:    res = a * b;
      FU_AND:    res = a & b;
      FU_OR:     res = a | b;
      FU_XOR:    res = a ^ b;
      FU_SLL:    res = a << w_sh;
      FU_SRL:    res = a >> w_sh;
      FU_SRA:    res = DATA_WIDTH'($signed(a) >>> w_sh);
      FU_SLT:    res = {{(DATA_WIDTH-1){1'b0}}, w_slt};
      FU_SLTU:   res = {{(DATA_WIDTH-1){1'b0}}, w_sltu};
      FU_PASS_A: res = a;
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/cgra_fu_rv.sv
// Elastic FU stage: joins two ready/valid operands (or folds in_a tokens in
// accumulate mode) and presents the result in one registered output slot.
module cgra_fu_rv
  import cgra_fu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ACC_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DATA_WIDTH-1:0]    in_a,
  input  logic                     in_a_v,
  output logic                     in_a_r,
  input  logic [DATA_WIDTH-1:0]    in_b,
  input  logic                     in_b_v,
  output logic                     in_b_r,
  output logic [DATA_WIDTH-1:0]    out,
  output logic                     out_v,
  input  logic                     out_r,
  input  logic [FU_OP_WIDTH-1:0]   cfg_op,
  input  logic                     cfg_acc_mode,
  input  logic [DATA_WIDTH-1:0]    cfg_init,
  input  logic [ACC_CNT_WIDTH-1:0] cfg_acc_iters
);

  logic [DATA_WIDTH-1:0]    r_out;
  logic                     r_out_v;
  logic [DATA_WIDTH-1:0]    r_acc;
  logic [ACC_CNT_WIDTH-1:0] r_cnt;

  logic                     w_slot_free;
  logic [ACC_CNT_WIDTH-1:0] w_iters_m1;
  logic                     w_last;
  logic                     w_fire;
  logic                     w_emit;
  logic [DATA_WIDTH-1:0]    w_acc_src;
  logic [DATA_WIDTH-1:0]    w_alu_a;
  logic [DATA_WIDTH-1:0]    w_alu_b;
  logic [DATA_WIDTH-1:0]    w_alu_res;

  assign w_slot_free = !r_out_v || r_out_r_dummy_free();

  // Helper kept as a plain expression; see function below.
  function automatic logic r_out_r_dummy_free();
    return out_r;
  endfunction

  // An iteration count of 0 behaves like 1: every token is the last one.
  assign w_iters_m1 = (cfg_acc_iters == '0) ? '0 : cfg_acc_iters - ACC_CNT_WIDTH'(1);
  assign w_last     = (r_cnt == w_iters_m1);

  // At the start of a group the fold seeds from cfg_init directly, so a
  // cfg_init update made while idle takes effect without another reset.
  assign w_acc_src = (r_cnt == '0) ? cfg_init : r_acc;

  // Intermediate folds never need the output slot; only the final one does.
  assign w_fire = enable && (cfg_acc_mode ? (in_a_v && (!w_last || w_slot_free))
                                          : (in_a_v && in_b_v && w_slot_free));
  assign w_emit = w_fire && (!cfg_acc_mode || w_last);

  assign in_a_r = w_fire;
  assign in_b_r = w_fire && !cfg_acc_mode;

  assign w_alu_a = cfg_acc_mode ? w_acc_src : in_a;
  assign w_alu_b = cfg_acc_mode ? in_a : in_b;

  cgra_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op (cfg_op),
    .a  (w_alu_a),
    .b  (w_alu_b),
    .res(w_alu_res)
  );

  // Output slot: load on emit, drain on downstream accept, hold when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_out_v <= 1'b0;
    end else if (enable) begin
      if (w_emit) begin
        r_out   <= w_alu_res;
        r_out_v <= 1'b1;
      end else if (r_out_v && out_r) begin
        r_out_v <= 1'b0;
      end
    end
  end

  // Accumulator and fold counter; reload after the final token of a group.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= cfg_init;
      r_cnt <= '0;
    end else if (w_fire && cfg_acc_mode) begin
      if (w_last) begin
        r_acc <= cfg_init;
        r_cnt <= '0;
      end else begin
        r_acc <= w_alu_res;
        r_cnt <= r_cnt + ACC_CNT_WIDTH'(1);
      end
    end
  end

  assign out   = r_out;
  assign out_v = r_out_v;

endmodule

// File: tb/tb_cgra_fu_rv.sv
// Self-checking bench for cgra_fu_rv: opcode vector table, directed
// handshake/accumulate sequences and randomized segments vs. a queue model.
module tb_cgra_fu_rv;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [DW-1:0] in_a;
  logic          in_a_v;
  logic          in_a_r;
  logic [DW-1:0] in_b;
  logic          in_b_v;
  logic          in_b_r;
  logic [DW-1:0] out;
  logic          out_v;
  logic          out_r;
  logic [3:0]    cfg_op;
  logic          cfg_acc_mode;
  logic [DW-1:0] cfg_init;
  logic [CW-1:0] cfg_acc_iters;

  cgra_fu_rv #(.DATA_WIDTH(DW), .ACC_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_a(in_a), .in_a_v(in_a_v), .in_a_r(in_a_r),
    .in_b(in_b), .in_b_v(in_b_v), .in_b_r(in_b_r),
    .out(out), .out_v(out_v), .out_r(out_r),
    .cfg_op(cfg_op), .cfg_acc_mode(cfg_acc_mode),
    .cfg_init(cfg_init), .cfg_acc_iters(cfg_acc_iters)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fired   = 0;
  int delivered = 0;

  // Model state: the output slot as a queue of at most one result, and the
  // in_a tokens collected so far for the current accumulate group.
  logic [DW-1:0] q[$];
  logic [DW-1:0] pend[$];

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sh;
    logic [2*DW-1:0] prod;
    sh = int'(b % DW);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  begin prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b}; return prod[DW-1:0]; end
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return a << sh;
      7:  return a >> sh;
      8:  return (a[DW-1]) ? ~((~a) >> sh) : (a >> sh);
      9:  return ($signed(a) < $signed(b)) ? 1 : 0;
      10: return (a < b) ? 1 : 0;
      11: return a;
      default: return '0;
    endcase
  endfunction

  // One clock cycle: drive, compare handshake/output against the model,
  // advance the model with the predicted transfers, then clock.
  task automatic do_cycle(input logic en, input logic av, input logic bv,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ordy);
    logic exp_fire;
    int n;
    logic [DW-1:0] r;
    enable = en; in_a_v = av; in_b_v = bv; in_a = a; in_b = b; out_r = ordy;
    #1;
    n = (cfg_acc_iters == 0) ? 1 : int'(cfg_acc_iters);
    if (cfg_acc_mode)
      exp_fire = en && av && ((pend.size() < n - 1) || q.size() == 0 || ordy);
    else
      exp_fire = en && av && bv && (q.size() == 0 || ordy);
    check("in_a_r", {31'b0, in_a_r}, {31'b0, exp_fire});
    check("in_b_r", {31'b0, in_b_r}, {31'b0, exp_fire && !cfg_acc_mode});
    check("out_v", {31'b0, out_v}, {31'b0, q.size() != 0});
    if (q.size() != 0) check("out", out, q[0]);
    if (en && q.size() != 0 && ordy) begin
      void'(q.pop_front());
      delivered++;
    end
    if (exp_fire) begin
      fired++;
      if (cfg_acc_mode) begin
        pend.push_back(a);
        if (pend.size() == n) begin
          r = cfg_init;
          foreach (pend[i]) r = ref_alu(int'(cfg_op), r, pend[i]);
          q.push_back(r);
          pend.delete();
        end
      end else begin
        q.push_back(ref_alu(int'(cfg_op), a, b));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Finish any partial group and empty the output slot before a cfg change.
  task automatic drain();
    for (int k = 0; k < 24 && (q.size() != 0 || pend.size() != 0); k++)
      do_cycle(1'b1, pend.size() != 0, 1'b0, $urandom, $urandom, 1'b1);
    check("drain_left", q.size() + pend.size(), 0);
    enable = 1'b1; in_a_v = 1'b0; in_b_v = 1'b0;
  endtask

  task automatic set_cfg(input logic mode, input logic [3:0] op,
                         input logic [DW-1:0] init, input logic [CW-1:0] iters);
    cfg_acc_mode = mode; cfg_op = op; cfg_init = init; cfg_acc_iters = iters;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd0,  32'd5,        32'd7,        32'd12};
    vecs[1]  = '{4'd1,  32'd10,       32'd3,        32'd7};
    vecs[2]  = '{4'd1,  32'd0,        32'd1,        32'hFFFF_FFFF};
    vecs[3]  = '{4'd2,  32'h0001_0000,32'h0001_0001,32'h0001_0000};
    vecs[4]  = '{4'd3,  32'hF0F0_F0F0,32'hFF00_FF00,32'hF000_F000};
    vecs[5]  = '{4'd4,  32'hF0F0_F0F0,32'hFF00_FF00,32'hFFF0_FFF0};
    vecs[6]  = '{4'd5,  32'hF0F0_F0F0,32'hFF00_FF00,32'h0FF0_0FF0};
    vecs[7]  = '{4'd6,  32'd1,        32'd35,       32'd8};
    vecs[8]  = '{4'd7,  32'h8000_0000,32'd4,        32'h0800_0000};
    vecs[9]  = '{4'd8,  32'h8000_0000,32'd4,        32'hF800_0000};
    vecs[10] = '{4'd9,  32'hFFFF_FFFF,32'd1,        32'd1};
    vecs[11] = '{4'd10, 32'hFFFF_FFFF,32'd1,        32'd0};
    vecs[12] = '{4'd11, 32'h1234_5678,32'h9999_9999,32'h1234_5678};
    vecs[13] = '{4'd15, 32'h1234_5678,32'h0000_0001,32'd0};
    vecs[14] = '{4'd2,  32'hFFFF_FFFF,32'hFFFF_FFFF,32'd1};

    rst = 1'b1; enable = 1'b1; in_a = '0; in_b = '0; in_a_v = 1'b0; in_b_v = 1'b0;
    out_r = 1'b1;
    set_cfg(1'b0, 4'd0, 32'd0, 16'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out", out, 32'd0);
    check("rst_out_v", {31'b0, out_v}, 32'd0);
    check("rst_in_a_r", {31'b0, in_a_r}, 32'd0);

    // Opcode table in normal mode, one token each, drained between tokens.
    for (int i = 0; i < 15; i++) begin
      cfg_op = vecs[i].op;
      do_cycle(1'b1, 1'b1, 1'b1, vecs[i].a, vecs[i].b, 1'b1);
      check($sformatf("vec%0d", i), out, vecs[i].exp);
      do_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    end

    // A lone operand must wait for its partner.
    cfg_op = 4'd1;
    repeat (3) do_cycle(1'b1, 1'b1, 1'b0, 32'd10, 32'd3, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b1, 32'd10, 32'd3, 1'b1);
    check("join_sub", out, 32'd7);
    drain();

    // XOR stream of 8 tokens while out_r toggles.
    cfg_op = 4'd5;
    fired = 0; delivered = 0;
    for (int c = 0; c < 40 && fired < 8; c++)
      do_cycle(1'b1, 1'b1, 1'b1, $urandom, $urandom, (c % 2) == 0);
    drain();
    check("xor_fired", fired, 8);
    check("xor_delivered", delivered, 8);

    // Accumulate ADD, init 100, 4 per group.
    set_cfg(1'b1, 4'd0, 32'd100, 16'd4);
    for (int t = 1; t <= 4; t++) do_cycle(1'b1, 1'b1, 1'b0, t, 32'hDEAD, 1'b1);
    check("acc_110", out, 32'd110);
    for (int t = 0; t < 4; t++) do_cycle(1'b1, 1'b1, 1'b0, 32'd1, 32'hBEEF, 1'b1);
    check("acc_104", out, 32'd104);
    drain();

    // acc_iters = 0 behaves as 1: every token emits.
    set_cfg(1'b1, 4'd2, 32'd3, 16'd0);
    for (int t = 0; t < 3; t++) begin
      do_cycle(1'b1, 1'b1, 1'b0, 32'd5, '0, 1'b1);
      check("acc_mul15", out, 32'd15);
    end
    drain();

    // Stalled slot with folds continuing, then reset mid-group.
    set_cfg(1'b1, 4'd0, 32'd100, 16'd4);
    for (int t = 0; t < 4; t++) do_cycle(1'b1, 1'b1, 1'b0, 32'd1, '0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0, 32'd10, '0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0, 32'd20, '0, 1'b0);
    check("stall_hold", out, 32'd104);
    rst = 1'b1; in_a_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); pend.delete();
    check("midrst_out_v", {31'b0, out_v}, 32'd0);
    for (int t = 1; t <= 4; t++) do_cycle(1'b1, 1'b1, 1'b0, t, '0, 1'b1);
    check("post_rst_110", out, 32'd110);
    drain();

    // enable low for 5 cycles in the middle of a group.
    do_cycle(1'b1, 1'b1, 1'b0, 32'd7, '0, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b0, 32'd8, '0, 1'b1);
    repeat (5) do_cycle(1'b0, 1'b1, 1'b0, 32'd50, '0, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b0, 32'd9, '0, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b0, 32'd10, '0, 1'b0);
    repeat (3) do_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("en_gap_134", out, 32'd134);
    drain();

    // Randomized segments in both modes against the model.
    for (int s = 0; s < 14; s++) begin
      set_cfg(1'($urandom % 2), 4'($urandom % 12), $urandom, 16'($urandom % 5));
      for (int c = 0; c < 40; c++)
        do_cycle(($urandom % 8) != 0, ($urandom % 10) < 7, ($urandom % 10) < 7,
                 $urandom, $urandom, ($urandom % 10) < 6);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
